// File: rtl/rs_ssc_corrector.sv
// Single-symbol-correcting decoder for the 80-bit RS(10,8) chipkill word over GF(2^8)/0x11D.
// Optional error counters are compiled in with `define ECC_ERR_CNT_EN.
module rs_ssc_corrector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [79:0] codeword_in,
  input  logic [15:0] syndrome_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic [1:0]  status_out,
  output logic [3:0]  err_pos_out
`ifdef ECC_ERR_CNT_EN
  ,
  input  logic        cnt_clr,
  output logic [15:0] ce_cnt,
  output logic [15:0] due_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_CE  = 2'b01;
  localparam logic [1:0] ST_DUE = 2'b10;
  localparam logic [3:0] POS_NONE = 4'd15;

  state_t      state_q, state_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  t_q, t_d;
  logic [7:0]  s0_q, s0_d;
  logic [7:0]  s1_q, s1_d;
  logic [63:0] data_q, data_d;
  logic [1:0]  status_q, status_d;
  logic [3:0]  err_pos_q, err_pos_d;

  // Multiply by alpha in GF(2^8) with primitive polynomial 0x11D.
  function automatic logic [7:0] mul_alpha(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    t_d       = t_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    data_d    = data_q;
    status_d  = status_q;
    err_pos_d = err_pos_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d    = codeword_in[79:16];
          s0_d      = syndrome_in[15:8];
          s1_d      = syndrome_in[7:0];
          j_d       = 3'd0;
          t_d       = syndrome_in[15:8];
          status_d  = ST_CE;
          err_pos_d = POS_NONE;
          state_d   = OUT;
          if (syndrome_in[15:8] == 8'h00 && syndrome_in[7:0] == 8'h00) begin
            status_d = ST_OK;
          end else if (syndrome_in[7:0] == 8'h00) begin
            err_pos_d = 4'd8;
          end else if (syndrome_in[15:8] == 8'h00) begin
            err_pos_d = 4'd9;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        // T tracks S0*alpha^j; a match means error value S0 sits in data symbol j.
        if (t_q == s1_q) begin
          for (int i = 0; i < 8; i++) begin
            if (3'(i) == j_q) begin
              data_d[8*(7-i) +: 8] = data_q[8*(7-i) +: 8] ^ s0_q;
            end
          end
          status_d  = ST_CE;
          err_pos_d = {1'b0, j_q};
          state_d   = OUT;
        end else if (j_q == 3'd7) begin
          status_d  = ST_DUE;
          err_pos_d = POS_NONE;
          state_d   = OUT;
        end else begin
          j_d = j_q + 3'd1;
          t_d = mul_alpha(t_q);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      j_q       <= 3'd0;
      t_q       <= 8'h00;
      s0_q      <= 8'h00;
      s1_q      <= 8'h00;
      data_q    <= 64'h0;
      status_q  <= ST_OK;
      err_pos_q <= POS_NONE;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      t_q       <= t_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      data_q    <= data_d;
      status_q  <= status_d;
      err_pos_q <= err_pos_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == OUT);
  assign data_out    = data_q;
  assign status_out  = status_q;
  assign err_pos_out = err_pos_q;

`ifdef ECC_ERR_CNT_EN
  logic [15:0] ce_q, ce_d;
  logic [15:0] due_q, due_d;
  logic        take;

  assign take = (state_q == OUT) && out_ready;

  always_comb begin
    ce_d  = ce_q;
    due_d = due_q;
    if (cnt_clr) begin
      ce_d  = 16'h0;
      due_d = 16'h0;
    end else if (take) begin
      if (status_q == ST_CE && ce_q != 16'hFFFF) ce_d = ce_q + 16'd1;
      if (status_q == ST_DUE && due_q != 16'hFFFF) due_d = due_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q  <= 16'h0;
      due_q <= 16'h0;
    end else begin
      ce_q  <= ce_d;
      due_q <= due_d;
    end
  end

  assign ce_cnt  = ce_q;
  assign due_cnt = due_q;
`endif

endmodule
